// File: rtl/pricing_pkg.sv
// ----------------------------------------------------------------------------
// pricing_pkg
//   Shared constants, state encodings and a small helper for the pricing
//   path-consumption stage.
//   - DW / N_PATH / N_DAY / ACC_W : datapath and run-length constants
//   - top_state_t                 : encodings of the top-level controller state
//   - acc_state_t                 : encodings of the day-accumulator FSM
//   - pos_diff()                  : unsigned max(x - k, 0) payoff term
// ----------------------------------------------------------------------------
package pricing_pkg;

    localparam int DW     = 12;   // sample / strike width (8 int . 4 frac)
    localparam int N_PATH = 256;  // samples per day per pass
    localparam int N_DAY  = 64;   // days per run
    localparam int ACC_W  = 32;   // holds N_PATH * (2^DW-1)^2 without overflow
    localparam int CNT_W  = 9;    // sample counter width
    localparam int DAY_W  = 6;    // day counter width (0..N_DAY-1)
    localparam int PROD_W = 2 * DW;

    // Top-level controller states; this block is only active in S_PRICING.
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PARAM   = 2'd1,
        S_SOBOL   = 2'd2,
        S_PRICING = 2'd3
    } top_state_t;

    // Day accumulator FSM: REG is the regression pass, PRICE the pricing pass.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REG   = 2'd1,
        PRICE = 2'd2,
        DONE  = 2'd3
    } acc_state_t;

    // Call payoff of one path sample against the strike, unsigned.
    function automatic logic [DW-1:0] pos_diff(input logic [DW-1:0] x,
                                               input logic [DW-1:0] k);
        return (x > k) ? (x - k) : '0;
    endfunction

endpackage

// File: rtl/pricing_mac.sv
// ----------------------------------------------------------------------------
// pricing_mac
//   Compare / square / accumulate datapath for one pass of path samples.
//   Holds the three running sums and also exposes their next values so the
//   parent can capture the final totals on the same edge that clears them.
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   clr          clear all accumulators (has priority over acc_en)
//   acc_en       add the current sample
//   price_mode   0: regression pass (moments always), 1: pricing pass
//                (moments only for in-the-money samples)
//   k            strike
//   x            path sample
//   acc_x/xx/pay current accumulator values
//   nxt_x/xx/pay accumulator values after this cycle's sample (if acc_en)
// ----------------------------------------------------------------------------
import pricing_pkg::*;

module pricing_mac (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             acc_en,
    input  logic             price_mode,
    input  logic [DW-1:0]    k,
    input  logic [DW-1:0]    x,
    output logic [ACC_W-1:0] acc_x,
    output logic [ACC_W-1:0] acc_xx,
    output logic [ACC_W-1:0] acc_pay,
    output logic [ACC_W-1:0] nxt_x,
    output logic [ACC_W-1:0] nxt_xx,
    output logic [ACC_W-1:0] nxt_pay
);

    logic              itm;
    logic              add_moments;
    logic [PROD_W-1:0] x_ext;
    logic [PROD_W-1:0] prod;
    logic [DW-1:0]     pay;

    // NOTE: combinational blocks assign every output a default first so no
    // path through the block leaves a signal unassigned (which would infer a latch).
    always_comb begin
        itm         = 1'b0;
        add_moments = 1'b0;
        x_ext       = '0;
        prod        = '0;
        pay         = '0;
        nxt_x       = acc_x;
        nxt_xx      = acc_xx;
        nxt_pay     = acc_pay;

        itm         = (x > k);
        // Pricing pass conditions the moments on the sample being in-the-money.
        add_moments = !price_mode || itm;
        // Zero-extend before multiplying so the full 24-bit square is kept.
        x_ext       = {{DW{1'b0}}, x};
        prod        = x_ext * x_ext;
        pay         = pos_diff(x, k);

        if (acc_en) begin
            nxt_pay = acc_pay + ACC_W'(pay);
            if (add_moments) begin
                nxt_x  = acc_x  + ACC_W'(x);
                nxt_xx = acc_xx + ACC_W'(prod);
            end
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_x   <= '0;
            acc_xx  <= '0;
            acc_pay <= '0;
        end else if (clr) begin
            acc_x   <= '0;
            acc_xx  <= '0;
            acc_pay <= '0;
        end else begin
            acc_x   <= nxt_x;
            acc_xx  <= nxt_xx;
            acc_pay <= nxt_pay;
        end
    end

endmodule

// File: rtl/pricing_day_accum.sv
// ----------------------------------------------------------------------------
// pricing_day_accum
//   Path-consumption stage of the pricing phase. Each day is streamed twice
//   (regression pass, then pricing pass) as N_PATH samples. Per-pass sums are
//   published with a one-cycle stat_valid pulse, and resend asks the source to
//   replay the day (after pass 0) or send the next day (after pass 1). After
//   the last day's pricing pass, done is raised and held.
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   en           high while the top controller is in S_PRICING
//   k_in         strike, stable while en = 1
//   in_valid/in  path sample stream, no back-pressure
//   resend       1-cycle replay / next-day request
//   stat_valid   1-cycle strobe for pass / day_idx / sum_*
//   pass         0 = regression, 1 = pricing (pass the stats belong to)
//   day_idx      day of the presented stats
//   sum_x        sum of x
//   sum_xx       sum of x*x
//   sum_pay      sum of max(x - k_in, 0)
//   done         held high after the final pricing pass
// ----------------------------------------------------------------------------
import pricing_pkg::*;

module pricing_day_accum (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [DW-1:0]    k_in,
    input  logic             in_valid,
    input  logic [DW-1:0]    in,
    output logic             resend,
    output logic             stat_valid,
    output logic             pass,
    output logic [DAY_W-1:0] day_idx,
    output logic [ACC_W-1:0] sum_x,
    output logic [ACC_W-1:0] sum_xx,
    output logic [ACC_W-1:0] sum_pay,
    output logic             done
);

    acc_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [DAY_W-1:0] day;

    logic             accept;
    logic             last_smp;
    logic             last_day;
    logic             mac_clr;

    logic [ACC_W-1:0] acc_x, acc_xx, acc_pay;
    logic [ACC_W-1:0] nxt_x, nxt_xx, nxt_pay;

    always_comb begin
        accept   = 1'b0;
        last_smp = 1'b0;
        last_day = 1'b0;
        mac_clr  = 1'b0;

        // The sample arriving alongside resend is dropped: the source is
        // restarting its stream on that cycle.
        accept   = en && in_valid && !resend && (state == REG || state == PRICE);
        last_smp = accept && (cnt == CNT_W'(N_PATH - 1));
        last_day = (day == DAY_W'(N_DAY - 1));
        // Final sums are captured from the mac's next values on the same edge
        // that clears it, so the next pass starts from zero with no gap cycle.
        mac_clr  = !en || last_smp;
    end

    pricing_mac u_mac (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (mac_clr),
        .acc_en     (accept),
        .price_mode (state == PRICE),
        .k          (k_in),
        .x          (in),
        .acc_x      (acc_x),
        .acc_xx     (acc_xx),
        .acc_pay    (acc_pay),
        .nxt_x      (nxt_x),
        .nxt_xx     (nxt_xx),
        .nxt_pay    (nxt_pay)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            day        <= '0;
            resend     <= 1'b0;
            stat_valid <= 1'b0;
            pass       <= 1'b0;
            day_idx    <= '0;
            sum_x      <= '0;
            sum_xx     <= '0;
            sum_pay    <= '0;
            done       <= 1'b0;
        end else begin
            // Strobes default low; published values hold unless overwritten.
            resend     <= 1'b0;
            stat_valid <= 1'b0;

            if (!en) begin
                state <= IDLE;
                cnt   <= '0;
                day   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        state <= REG;
                        done  <= 1'b0;  // a new run starts
                    end

                    REG, PRICE: begin
                        if (last_smp) begin
                            cnt        <= '0;
                            stat_valid <= 1'b1;
                            pass       <= (state == PRICE);
                            day_idx    <= day;
                            sum_x      <= nxt_x;
                            sum_xx     <= nxt_xx;
                            sum_pay    <= nxt_pay;
                            if (state == REG) begin
                                state  <= PRICE;
                                resend <= 1'b1;
                            end else if (last_day) begin
                                state  <= DONE;
                                done   <= 1'b1;
                            end else begin
                                state  <= REG;
                                day    <= day + 1'b1;
                                resend <= 1'b1;
                            end
                        end else if (accept) begin
                            cnt <= cnt + 1'b1;
                        end
                    end

                    DONE: begin
                        state <= DONE;
                    end

                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pricing_day_accum.sv
// ----------------------------------------------------------------------------
// tb_pricing_day_accum
//   Directed bench for pricing_day_accum with hand-computed expected sums.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_pricing_day_accum;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [11:0] k_in;
    logic        in_valid;
    logic [11:0] in_x;
    logic        resend;
    logic        stat_valid;
    logic        pass;
    logic [5:0]  day_idx;
    logic [31:0] sum_x;
    logic [31:0] sum_xx;
    logic [31:0] sum_pay;
    logic        done;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic        sv;
        logic        rs;
        logic        ps;
        logic        dn;
        logic [5:0]  d;
        logic [31:0] x;
        logic [31:0] xx;
        logic [31:0] pay;
    } stat_t;

    pricing_day_accum dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .k_in       (k_in),
        .in_valid   (in_valid),
        .in         (in_x),
        .resend     (resend),
        .stat_valid (stat_valid),
        .pass       (pass),
        .day_idx    (day_idx),
        .sum_x      (sum_x),
        .sum_xx     (sum_xx),
        .sum_pay    (sum_pay),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic stat_t obs();
        stat_t s;
        s.sv  = stat_valid;
        s.rs  = resend;
        s.ps  = pass;
        s.dn  = done;
        s.d   = day_idx;
        s.x   = sum_x;
        s.xx  = sum_xx;
        s.pay = sum_pay;
        return s;
    endfunction

    function automatic string fmt(input stat_t s);
        return $sformatf("sv=%b rs=%b pass=%b done=%b day=%0d x=%h xx=%h pay=%h",
                         s.sv, s.rs, s.ps, s.dn, s.d, s.x, s.xx, s.pay);
    endfunction

    function automatic stat_t mk(input logic sv, input logic rs, input logic ps,
                                 input logic dn, input int d, input logic [31:0] x,
                                 input logic [31:0] xx, input logic [31:0] pay);
        stat_t s;
        s.sv = sv; s.rs = rs; s.ps = ps; s.dn = dn; s.d = 6'(d);
        s.x = x; s.xx = xx; s.pay = pay;
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Streams n accepted samples of value x; gap>0 inserts an idle cycle
    // before every gap-th sample. Ends #1 after the last sample edge.
    task automatic stream(input logic [11:0] x, input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            if (gap != 0 && (i % gap) == gap - 1) begin
                in_valid = 1'b0;
                tick();
            end
            in_valid = 1'b1;
            in_x     = x;
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        stat_t got, exp;
        rst_n = 1'b0; en = 1'b0; k_in = '0; in_valid = 1'b0; in_x = '0;
        #12;
        got = obs();
        exp = mk(0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL reset_state: got %s want %s", fmt(got), fmt(exp));
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        stat_t got, exp;
        k_in = 12'h020;
        en   = 1'b1;
        tick();  // IDLE -> REG

        stream(12'h030, 256, 0);
        got = obs(); exp = mk(1, 1, 0, 0, 0, 32'h3000, 32'h90000, 32'h1000);
        checks++;
        if (got !== exp) begin
            errors++; $display("FAIL d0_pass0: got %s want %s", fmt(got), fmt(exp));
        end
        tick();
        got = obs(); exp = mk(0, 0, 0, 0, 0, 32'h3000, 32'h90000, 32'h1000);
        checks++;
        if (got !== exp) begin
            errors++; $display("FAIL d0_pass0_hold: got %s want %s", fmt(got), fmt(exp));
        end

        stream(12'h030, 256, 0);
        got = obs(); exp = mk(1, 1, 1, 0, 0, 32'h3000, 32'h90000, 32'h1000);
        checks++;
        if (got !== exp) begin
            errors++; $display("FAIL d0_pass1: got %s want %s", fmt(got), fmt(exp));
        end
        tick();

        stream(12'h010, 256, 0);
        got = obs(); exp = mk(1, 1, 0, 0, 1, 32'h1000, 32'h10000, 32'h0);
        checks++;
        if (got !== exp) begin
            errors++; $display("FAIL d1_pass0_otm: got %s want %s", fmt(got), fmt(exp));
        end
        tick();

        stream(12'h010, 256, 0);
        got = obs(); exp = mk(1, 1, 1, 0, 1, 32'h0, 32'h0, 32'h0);
        checks++;
        if (got !== exp) begin
            errors++; $display("FAIL d1_pass1_otm: got %s want %s", fmt(got), fmt(exp));
        end
    endtask

    // Entered on the resend cycle that ends day 1.
    task automatic test_drop_and_gaps();
        stat_t got, exp;
        in_valid = 1'b1;
        in_x     = 12'hFFF;  // must be dropped
        tick();
        in_valid = 1'b0;

        stream(12'h030, 256, 3);
        got = obs(); exp = mk(1, 1, 0, 0, 2, 32'h3000, 32'h90000, 32'h1000);
        checks++;
        if (got !== exp) begin
            errors++; $display("FAIL drop_gap_pass0: got %s want %s", fmt(got), fmt(exp));
        end
        tick();

        stream(12'h030, 256, 5);
        got = obs(); exp = mk(1, 1, 1, 0, 2, 32'h3000, 32'h90000, 32'h1000);
        checks++;
        if (got !== exp) begin
            errors++; $display("FAIL gap_pass1: got %s want %s", fmt(got), fmt(exp));
        end
        tick();
    endtask

    task automatic test_en_drop();
        stat_t got, exp;
        stream(12'h030, 100, 0);
        en = 1'b0;
        tick();
        got = obs(); exp = mk(0, 0, 1, 0, 2, 32'h3000, 32'h90000, 32'h1000);
        checks++;
        if (got !== exp) begin
            errors++; $display("FAIL en_drop_hold: got %s want %s", fmt(got), fmt(exp));
        end
        en = 1'b1;
        tick();  // IDLE -> REG

        stream(12'h010, 256, 0);
        got = obs(); exp = mk(1, 1, 0, 0, 0, 32'h1000, 32'h10000, 32'h0);
        checks++;
        if (got !== exp) begin
            errors++; $display("FAIL en_restart: got %s want %s", fmt(got), fmt(exp));
        end
        tick();
    endtask

    task automatic test_full_run();
        stat_t got, exp;
        logic  last;
        en = 1'b0;
        tick();
        k_in = 12'h000;
        en   = 1'b1;
        tick();
        for (int d = 0; d < 64; d++) begin
            for (int p = 0; p < 2; p++) begin
                last = (d == 63) && (p == 1);
                stream(12'hFFF, 256, 0);
                got = obs();
                exp = mk(1, !last, p[0], last, d, 32'hFFF00, 32'hFFE00100, 32'hFFF00);
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL full_d%0d_p%0d: got %s want %s", d, p, fmt(got), fmt(exp));
                end
                tick();
            end
        end
        // DONE ignores further samples and keeps done/stats.
        stream(12'h123, 256, 0);
        tick();
        got = obs(); exp = mk(0, 0, 1, 1, 63, 32'hFFF00, 32'hFFE00100, 32'hFFF00);
        checks++;
        if (got !== exp) begin
            errors++; $display("FAIL done_hold: got %s want %s", fmt(got), fmt(exp));
        end
    endtask

    task automatic test_async_reset();
        stat_t got, exp;
        en = 1'b0;
        tick();
        en = 1'b1;
        tick();
        stream(12'h030, 50, 0);
        #3;
        rst_n = 1'b0;
        #1;
        got = obs(); exp = mk(0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (got !== exp) begin
            errors++; $display("FAIL async_reset: got %s want %s", fmt(got), fmt(exp));
        end
        en = 1'b0;
        #10;
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_drop_and_gaps();
        test_en_drop();
        test_full_run();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
